// File: rtl/cg_merge_regbank.sv
// cg_merge_regbank: multi-lane capture bank with per-lane gating enables, recirculation and idle counter.
// FORCE_SAME_COND_EN merges all lane enables into one shared gate condition.
module cg_merge_regbank #(
  parameter int LANES = 4,
  parameter int LANE_W = 8,
  parameter int ROT_STEP = 1,
  parameter logic [LANES-1:0] ROT_MASK = LANES'(4'b0101),
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic                    last,
  input  logic                    clr_cnt,
  input  logic [LANES*LANE_W-1:0] in,
  output logic [LANES*LANE_W-1:0] out,
  output logic [LANES-1:0]        en_vec,
  output logic                    upd,
  output logic [CNT_W-1:0]        idle_cnt
);
  logic [LANES*LANE_W-1:0] nxt;
  // next value is purely data-driven; held lanes resolve to self so the enable never shapes data
  always_comb begin
    nxt = out;
    for (int i = 0; i < LANES; i++)
      nxt[i*LANE_W +: LANE_W] = valid ? in[i*LANE_W +: LANE_W] :
                                (~last & ROT_MASK[i]) ? out[((i + ROT_STEP) % LANES)*LANE_W +: LANE_W] :
                                out[i*LANE_W +: LANE_W];
  end
`ifdef FORCE_SAME_COND_EN
  always_comb en_vec = {LANES{~rst & (valid | (~last & |ROT_MASK))}};
`else
  always_comb en_vec = rst ? '0 : ({LANES{valid}} | ({LANES{~last}} & ROT_MASK));
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
      upd <= 1'b0;
      idle_cnt <= '0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (en_vec[i]) out[i*LANE_W +: LANE_W] <= nxt[i*LANE_W +: LANE_W];
      upd <= |en_vec;
      idle_cnt <= clr_cnt ? '0 : (~|en_vec && ~&idle_cnt) ? idle_cnt + 1'b1 : idle_cnt;
    end
  end
endmodule

// File: tb/tb_cg_merge_regbank.sv
// tb_cg_merge_regbank: scoreboard bench with a lane-array reference model for cg_merge_regbank.
module tb_cg_merge_regbank;
  localparam int L = 4;
  localparam int STEP = 1;
  localparam logic [3:0] MASK = 4'b0101;
  logic clk = 1'b0;
  logic rst = 1'b1, valid = 1'b0, last = 1'b0, clr_cnt = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] out, out_s;
  logic [3:0] en_vec, en_s;
  logic upd, upd_s;
  logic [15:0] idle_cnt;
  logic [2:0] idle_s;
  int checks = 0, failures = 0;
  typedef struct {
    logic [31:0] o;
    logic u;
    logic [15:0] c;
    logic [2:0] cs;
    logic [3:0] e;
  } exp_t;
  exp_t q[$];
  int lane[L];
  bit m_upd;
  int m_cnt, m_cs;
  always #5 clk = ~clk;
  cg_merge_regbank dut (.clk(clk), .rst(rst), .valid(valid), .last(last), .clr_cnt(clr_cnt),
    .in(din), .out(out), .en_vec(en_vec), .upd(upd), .idle_cnt(idle_cnt));
  cg_merge_regbank #(.CNT_W(3)) u_sat (.clk(clk), .rst(rst), .valid(valid), .last(last), .clr_cnt(clr_cnt),
    .in(din), .out(out_s), .en_vec(en_s), .upd(upd_s), .idle_cnt(idle_s));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask
  // issue one cycle of stimulus; the expectation pushed is what the DUT shows during this cycle
  task automatic step(input bit r, input bit v, input bit l, input bit c, input logic [31:0] d);
    exp_t e;
    int nl[L];
    bit any;
    @(posedge clk);
    #1;
    rst = r; valid = v; last = l; clr_cnt = c; din = d;
    e.o = {lane[3][7:0], lane[2][7:0], lane[1][7:0], lane[0][7:0]};
    e.u = m_upd; e.c = 16'(m_cnt); e.cs = 3'(m_cs);
    any = 0;
    for (int i = 0; i < L; i++) begin
`ifdef FORCE_SAME_COND_EN
      e.e[i] = !r && (v || (!l && MASK != 0));
`else
      e.e[i] = !r && (v || (!l && MASK[i]));
`endif
      any |= e.e[i];
    end
    q.push_back(e);
    if (r) begin
      foreach (lane[i]) lane[i] = 0;
      m_upd = 0; m_cnt = 0; m_cs = 0;
    end else begin
      for (int i = 0; i < L; i++)
        nl[i] = v ? int'(d[i*8 +: 8]) : (!l && MASK[i]) ? lane[(i + STEP) % L] : lane[i];
      lane = nl;
      m_upd = any;
      m_cnt = c ? 0 : any ? m_cnt : (m_cnt < 65535 ? m_cnt + 1 : m_cnt);
      m_cs = c ? 0 : any ? m_cs : (m_cs < 7 ? m_cs + 1 : m_cs);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("out", out, e.o);
      chk("out_sat", out_s, e.o);
      chk("upd", 32'(upd), 32'(e.u));
      chk("idle_cnt", 32'(idle_cnt), 32'(e.c));
      chk("idle_cnt_w3", 32'(idle_s), 32'(e.cs));
      chk("en_vec", 32'(en_vec), 32'(e.e));
    end
  end
  initial begin
    foreach (lane[i]) lane[i] = 0;
    m_upd = 0; m_cnt = 0; m_cs = 0;
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 32'hFFFF_FFFF);
    step(0, 1, 0, 0, 32'hA1B2C3D4);
    step(0, 1, 0, 0, 32'h44332211);
    step(0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, $urandom);
    for (int k = 0; k < 5; k++) step(0, 0, 1, k == 2, $urandom);
    step(0, 1, 1, 0, 32'h5A6B7C8D);
    for (int k = 0; k < 10; k++) step(0, 0, 1, 0, $urandom);
    step(0, 1, 0, 0, 32'h11223344);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 11) == 0, $urandom);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
